// File: rtl/aes128_key_expander_if.sv
// Round-key stream bundle between the AES-128 key expander (master) and the round datapath (slave).
// The dir select only exists when AES_KEY_DECRYPT_EN is defined.
interface aes128_key_expander_if;
  logic         start;
  logic [127:0] key_in;
`ifdef AES_KEY_DECRYPT_EN
  logic         dir;
`endif
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;

`ifdef AES_KEY_DECRYPT_EN
  modport master (
    input  start, key_in, dir, rk_ready,
    output rk_valid, rk_out, rk_index, busy, done
  );

  modport slave (
    output start, key_in, dir, rk_ready,
    input  rk_valid, rk_out, rk_index, busy, done
  );
`else
  modport master (
    input  start, key_in, rk_ready,
    output rk_valid, rk_out, rk_index, busy, done
  );

  modport slave (
    output start, key_in, rk_ready,
    input  rk_valid, rk_out, rk_index, busy, done
  );
`endif
endinterface

// File: rtl/aes128_key_expander.sv
// Sequential AES-128 key schedule: computes one round key per accepted transfer and streams keys 0..NR.
// Optional macro AES_KEY_DECRYPT_EN adds a dir input and reverse delivery (NR..0) after a warm-up pass.
module aes128_key_expander #(
  parameter int NR = 10
) (
  input logic                   clk,
  input logic                   rst,
  aes128_key_expander_if.master bus
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  if (NR != 10) begin : g_bad_nr
    $error("aes128_key_expander: only NR=10 (AES-128) is supported");
  end

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(11'd2047 - {b, 3'b000}) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;
    t  = sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = n0 ^ k[95:64];
    n2 = n1 ^ k[63:32];
    n3 = n2 ^ k[31:0];
    return {n0, n1, n2, n3};
  endfunction

`ifdef AES_KEY_DECRYPT_EN
  // Only 8'h80 produces a carry in the rcon sequence, so 8'h1b is the one byte that maps back to it.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return (b == 8'h1b) ? 8'h80 : {1'b0, b[7:1]};
  endfunction

  function automatic logic [127:0] rev_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_word(rot_word(p3)) ^ {rc, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction
`endif

`ifdef AES_KEY_DECRYPT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EMIT = 2'b01,
    ST_WARM = 2'b10
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EMIT = 2'b01
  } state_t;
`endif

  state_t       state_q;
  state_t       state_d;
  logic [127:0] key_q;
  logic [127:0] key_d;
  logic [7:0]   rcon_q;
  logic [7:0]   rcon_d;
  logic [3:0]   idx_q;
  logic [3:0]   idx_d;
  logic         valid_q;
  logic         valid_d;
  logic         busy_q;
  logic         busy_d;
  logic         done_q;
  logic         done_d;
  logic [127:0] fwd_key_s;
  logic [3:0]   last_idx_s;

  assign fwd_key_s = fwd_step(key_q, rcon_q);

`ifdef AES_KEY_DECRYPT_EN
  logic         dir_q;
  logic         dir_d;
  logic [127:0] rev_key_s;

  // key_q holds round r, so the rcon that built it is one inverse step behind rcon_q.
  assign rev_key_s  = rev_step(key_q, inv_xtime(rcon_q));
  assign last_idx_s = dir_q ? 4'd0 : NR_IDX;
`else
  assign last_idx_s = NR_IDX;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= 128'h0;
      rcon_q  <= 8'h01;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_KEY_DECRYPT_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef AES_KEY_DECRYPT_EN
      dir_q   <= dir_d;
`endif
    end
  end

  // Next-state and next-key selection.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef AES_KEY_DECRYPT_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          key_d  = bus.key_in;
          rcon_d = 8'h01;
          idx_d  = 4'd0;
          busy_d = 1'b1;
`ifdef AES_KEY_DECRYPT_EN
          dir_d  = bus.dir;
          if (bus.dir) begin
            state_d = ST_WARM;
            valid_d = 1'b0;
          end else begin
            state_d = ST_EMIT;
            valid_d = 1'b1;
          end
`else
          state_d = ST_EMIT;
          valid_d = 1'b1;
`endif
        end else begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
`ifdef AES_KEY_DECRYPT_EN
      ST_WARM: begin
        key_d  = fwd_key_s;
        rcon_d = xtime(rcon_q);
        if (idx_q == (NR_IDX - 4'd1)) begin
          idx_d   = NR_IDX;
          state_d = ST_EMIT;
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`endif
      ST_EMIT: begin
        if (valid_q && bus.rk_ready) begin
          if (idx_q == last_idx_s) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef AES_KEY_DECRYPT_EN
          end else if (dir_q) begin
            key_d  = rev_key_s;
            rcon_d = inv_xtime(rcon_q);
            idx_d  = idx_q - 4'd1;
`endif
          end else begin
            key_d  = fwd_key_s;
            rcon_d = xtime(rcon_q);
            idx_d  = idx_q + 4'd1;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.rk_valid = valid_q;
  assign bus.rk_out   = key_q;
  assign bus.rk_index = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes128_key_expander.sv
// Randomized bench for aes128_key_expander against a FIPS-197 word-array key expansion model.
// Exercises reverse order too when AES_KEY_DECRYPT_EN is defined.
`timescale 1ns/1ps
module tb_aes128_key_expander;
  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_ready = 1'b0;
  logic dir_sel = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aes128_key_expander_if bus ();

  aes128_key_expander #(.NR(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef AES_KEY_DECRYPT_EN
  assign bus.dir = dir_sel;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // GF(2^8) arithmetic for building the S-box from its algebraic definition
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0]   sbox_tab [256];
  logic [127:0] m_keys [0:10];

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Transaction-level model: what the next cycle must look like given this cycle's inputs
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  logic m_dir  = 1'b0;
  int   m_pos  = 0;
  int   m_warm = 0;

  always @(negedge clk) begin
    logic exp_valid;
    int   idx;
    exp_valid = m_busy && (m_warm == 0);
    if (chk_en) begin
      check("rk_valid", 128'(bus.rk_valid), 128'(exp_valid));
      check("busy", 128'(bus.busy), 128'(m_busy));
      check("done", 128'(bus.done), 128'(m_done));
      if (exp_valid) begin
        idx = m_dir ? (NR - m_pos) : m_pos;
        check("rk_index", 128'(bus.rk_index), 128'(idx));
        check("rk_out", bus.rk_out, m_keys[idx]);
      end
    end
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_warm = 0;
      m_pos  = 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        expand(bus.key_in);
        m_busy = 1'b1;
        m_pos  = 0;
        m_dir  = dir_sel;
        m_warm = dir_sel ? NR : 0;
      end
    end else if (m_warm > 0) begin
      m_warm--;
    end else if (bus.rk_ready) begin
      if (m_pos == NR) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_pos++;
      end
    end
  end

  // Consumer readiness: held high, or random per cycle
  always @(posedge clk) begin
    #1;
    bus.rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic run_key(input logic [127:0] key, input logic d);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.key_in = key;
    dir_sel    = d;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 128'(seen), 128'(1'b1));
  endtask

  task automatic wait_idx(input logic [3:0] target, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.rk_valid && bus.rk_index == target) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 128'(seen), 128'(1'b1));
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.key_in = 128'h0;

    build_sbox();
    check("model_sbox_00", 128'(sbox_tab[8'h00]), 128'(8'h63));
    check("model_sbox_53", 128'(sbox_tab[8'h53]), 128'(8'hed));
    expand(FIPS_KEY);
    check("model_fips_rk1", m_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_fips_rk10", m_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    expand(128'h0);
    check("model_zero_rk1", m_keys[1], 128'h62636363626363636263636362636363);
    check("model_zero_rk10", m_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rk_valid", 128'(bus.rk_valid), 128'(1'b0));
    check("reset_rk_out", bus.rk_out, 128'h0);
    check("reset_rk_index", 128'(bus.rk_index), 128'(4'd0));
    check("reset_busy", 128'(bus.busy), 128'(1'b0));
    check("reset_done", 128'(bus.done), 128'(1'b0));
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    run_key(FIPS_KEY, 1'b0);
    wait_done("done_fips_ready_high");

    rand_ready = 1'b1;
    run_key(FIPS_KEY, 1'b0);
    wait_done("done_fips_random_ready");

    rand_ready = 1'b0;
    run_key(FIPS_KEY, 1'b0);
    wait_idx(4'd4, "reach_index4");
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.key_in = 128'h00112233445566778899aabbccddeeff;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    wait_done("done_after_ignored_start");

    run_key(FIPS_KEY, 1'b0);
    wait_idx(4'd6, "reach_index6");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_rk_out", bus.rk_out, 128'h0);
    check("midreset_rk_index", 128'(bus.rk_index), 128'(4'd0));
    repeat (3) @(posedge clk);
    run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_done("done_after_midreset");

    rand_ready = 1'b1;
    run_key(128'h0, 1'b0);
    wait_done("done_zero_key");

    for (int n = 0; n < 4; n++) begin
      run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      wait_done("done_random_key");
    end

`ifdef AES_KEY_DECRYPT_EN
    rand_ready = 1'b0;
    run_key(FIPS_KEY, 1'b1);
    wait_done("done_reverse_fips");
    rand_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      wait_done("done_reverse_random");
    end
    dir_sel = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_key_expander.md
Name: aes128_key_expander

Overview:
- Sequential AES-128 key schedule. Generates round keys 0..NR one at a time from a 128-bit cipher key.
- Delivers each key over a valid/ready stream to the round datapath, where it is XORed into the state by the existing round-key add stage.
- Producer side of the round-key interface: computes one 128-bit key per accepted transfer, so no 11-entry key store is needed.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is a configuration error.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  begin expansion of key_in; sampled only in IDLE
- key_in  input  128  cipher key; byte 0 = key_in[127:120]
- rk_ready  input  1  consumer accepts rk_out this cycle
- rk_valid  output  1  rk_out/rk_index valid
- rk_out  output  128  current round key; word w0 = [127:96]
- rk_index  output  4  round number of rk_out (0..NR)
- busy  output  1  high from start acceptance until final key accepted
- done  output  1  one-cycle pulse after round key NR is accepted

Behaviour:
- Reset state: rk_valid=0, rk_out=0, rk_index=0, busy=0, done=0, state IDLE, rcon=8'h01.
  - rst has priority over all other inputs.
  - rst mid-sequence aborts immediately; no done pulse is produced.
- States: IDLE, EMIT (plus WARM with the optional feature).
- IDLE:
  - start=1 latches key_in into the key register.
  - Next cycle: rk_valid=1, rk_index=0, rk_out=key_in, busy=1; state moves to EMIT.
  - Latency from start to the first valid key is 1 cycle.
- EMIT, handshake:
  - A transfer occurs when rk_valid && rk_ready.
  - While rk_valid && !rk_ready, rk_out and rk_index hold stable.
- EMIT, on a transfer with rk_index<NR:
  - Next key registered; rk_index increments.
  - rk_valid stays 1, so throughput is 1 key/cycle with rk_ready held high.
- EMIT, on a transfer with rk_index==NR:
  - rk_valid=0, busy=0, done=1 for one cycle; state returns to IDLE.
- Forward step, with current words w0..w3 and t = SubWord(RotWord(w3)) ^ {rcon,24'h0}:
  - n0=w0^t, n1=n0^w1, n2=n1^w2, n3=n2^w3.
- Word operations:
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the AES S-box to each byte; uses the shared S-box function, 4 instances, combinational.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Update is xtime: shift left, XOR 8'h1B on carry-out.
  - Advances on each forward step; reloads 8'h01 on start.
- start while busy is ignored; key_in changes after latch have no effect.
- Single clock; no combinational path from rk_ready to rk_out. rk_valid is registered.

Optional Feature:
- Macro: AES_KEY_DECRYPT_EN.
- Adds input port dir (1 bit), sampled with start: 0 = forward order, 1 = reverse order.
- dir=1 flow:
  - start enters WARM and runs NR forward steps internally with rk_valid=0, busy=1.
  - It then enters EMIT, presenting rk_index=NR first, and decrements rk_index on each transfer down to 0.
  - done pulses after index 0 is accepted.
  - First valid key appears NR+1 cycles after start.
- Reverse step, with current words w0..w3 and the rcon of the current round:
  - p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon,24'h0}.
  - rcon steps back by inverse xtime: shift right, and if the source byte was 8'h1B the result is 8'h80.
- Without the macro: no dir port, no WARM state, forward order only.

Test Plan:
- Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1 -> rk_index 0..10 on 11 consecutive cycles.
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses the cycle after rk10; busy falls the same cycle.
- Same key, rk_ready toggled randomly -> rk_out/rk_index are stable whenever valid && !ready; the same 11 keys arrive in order.
- Pulse start again while busy at rk_index=4 with a different key_in -> ignored; the sequence continues to rk10 of the original key.
- Assert rst at rk_index=6 -> next cycle rk_valid=0, busy=0, no done. A new start then produces rk0 = the new key.
- Key all-zero -> rk1 = 62636363626363636263636362636363; rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- AES_KEY_DECRYPT_EN, dir=1, FIPS key -> no valid for 10 cycles, then rk10 = d014f9a8..., rk9, ..., rk0 = 2b7e1516...; done after rk0.
